// File: rtl/branch_resolve_ctrl.sv
// Tracks in-flight gshare predictions in a FIFO; on resolution it issues the counter update and,
// on a mispredict, flushes, redirects fetch and restores the GHR.
module branch_resolve_ctrl #(
   parameter int unsigned ADDRESS_WIDTH = 22,
   parameter int unsigned GHR_SIZE      = 8,
   parameter int unsigned DEPTH         = 4
) (
   input  logic                       i_Clk,
   input  logic                       i_Reset,
   input  logic                       i_Stall,
   input  logic                       i_Pred_valid,
   input  logic [ADDRESS_WIDTH-1:0]   i_Pred_pc,
   input  logic                       i_Pred_taken,
   input  logic [GHR_SIZE-1:0]        i_Pred_ghr,
   input  logic                       i_Resolve_valid,
   input  logic                       i_Resolve_taken,
   input  logic [ADDRESS_WIDTH-1:0]   i_Resolve_target,
   output logic                       o_Fetch_hold,
   output logic                       o_Flush,
   output logic [ADDRESS_WIDTH-1:0]   o_Redirect_pc,
   output logic                       o_Ghr_restore_valid,
   output logic [GHR_SIZE-1:0]        o_Ghr_restore,
   output logic                       o_Update_valid,
   output logic [GHR_SIZE-1:0]        o_Update_index,
   output logic                       o_Update_taken,
   output logic [$clog2(DEPTH):0]     o_Inflight,
   output logic                       o_Underflow
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [1:0] StRun     = 2'd0;
   localparam logic [1:0] StFlush   = 2'd1;
   localparam logic [1:0] StRecover = 2'd2;

   logic [ADDRESS_WIDTH-1:0] r_pc_mem    [DEPTH];
   logic                     r_taken_mem [DEPTH];
   logic [GHR_SIZE-1:0]      r_ghr_mem   [DEPTH];

   logic [PTR_W-1:0]         r_rd_ptr;
   logic [PTR_W-1:0]         r_wr_ptr;
   logic [CNT_W-1:0]         r_count;
   logic [1:0]               r_state;
   logic                     r_update_valid;
   logic [GHR_SIZE-1:0]      r_update_index;
   logic                     r_update_taken;
   logic [ADDRESS_WIDTH-1:0] r_redirect_pc;
   logic [GHR_SIZE-1:0]      r_ghr_restore;
   logic                     r_underflow;

   logic                     w_run;
   logic                     w_full;
   logic                     w_empty;
   logic                     w_pop;
   logic                     w_push;
   logic                     w_mispred;
   logic                     w_push_keep;
   logic                     w_underflow_evt;
   logic [ADDRESS_WIDTH-1:0] w_head_pc;
   logic                     w_head_taken;
   logic [GHR_SIZE-1:0]      w_head_ghr;

   always_comb begin
      w_run           = (r_state == StRun);
      w_full          = (r_count == CNT_W'(DEPTH));
      w_empty         = (r_count == '0);
      w_head_pc       = r_pc_mem[r_rd_ptr];
      w_head_taken    = r_taken_mem[r_rd_ptr];
      w_head_ghr      = r_ghr_mem[r_rd_ptr];
      w_pop           = i_Resolve_valid & ~i_Stall & w_run & ~w_empty;
      w_push          = i_Pred_valid & ~i_Stall & w_run & (~w_full | w_pop);
      w_mispred       = w_pop & (i_Resolve_taken != w_head_taken);
      // Records pushed alongside a mispredict are wrong-path and never stored.
      w_push_keep     = w_push & ~w_mispred;
      w_underflow_evt = i_Resolve_valid & ~i_Stall & w_run & w_empty;
   end

   always_ff @(posedge i_Clk) begin
      if (w_push_keep) begin
         r_pc_mem[r_wr_ptr]    <= i_Pred_pc;
         r_taken_mem[r_wr_ptr] <= i_Pred_taken;
         r_ghr_mem[r_wr_ptr]   <= i_Pred_ghr;
      end
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (w_mispred) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_keep) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)       r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_keep, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Recovery states advance regardless of i_Stall so a flush can never be lost.
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         r_state <= StRun;
      end else begin
         case (r_state)
            StRun:     r_state <= w_mispred ? StFlush : StRun;
            StFlush:   r_state <= StRecover;
            StRecover: r_state <= StRun;
            default:   r_state <= StRun;
         endcase
      end
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         r_update_valid <= 1'b0;
         r_update_index <= '0;
         r_update_taken <= 1'b0;
         r_redirect_pc  <= '0;
         r_ghr_restore  <= '0;
         r_underflow    <= 1'b0;
      end else begin
         r_update_valid <= w_pop;
         if (w_pop) begin
            r_update_index <= w_head_ghr ^ w_head_pc[GHR_SIZE-1:0];
            r_update_taken <= i_Resolve_taken;
         end
         if (w_mispred) begin
            r_redirect_pc <= i_Resolve_target;
            r_ghr_restore <= {w_head_ghr[GHR_SIZE-2:0], i_Resolve_taken};
         end
         if (w_underflow_evt) r_underflow <= 1'b1;
      end
   end

   always_comb begin
      o_Fetch_hold        = w_full | ~w_run;
      o_Flush             = (r_state == StFlush);
      o_Ghr_restore_valid = (r_state == StFlush);
      o_Redirect_pc       = r_redirect_pc;
      o_Ghr_restore       = r_ghr_restore;
      o_Update_valid      = r_update_valid;
      o_Update_index      = r_update_index;
      o_Update_taken      = r_update_taken;
      o_Inflight          = r_count;
      o_Underflow         = r_underflow;
   end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: fill/drain, correct resolve, mispredict recovery,
// stall during flush, underflow and reset during flush.
module tb_branch_resolve_ctrl;

   localparam int unsigned AW  = 22;
   localparam int unsigned GHR = 8;
   localparam int unsigned DEP = 4;

   logic            clk;
   logic            rst;
   logic            stall;
   logic            pred_valid;
   logic [AW-1:0]   pred_pc;
   logic            pred_taken;
   logic [GHR-1:0]  pred_ghr;
   logic            res_valid;
   logic            res_taken;
   logic [AW-1:0]   res_target;
   logic            fetch_hold;
   logic            flush;
   logic [AW-1:0]   redirect_pc;
   logic            ghr_rv;
   logic [GHR-1:0]  ghr_restore;
   logic            upd_valid;
   logic [GHR-1:0]  upd_index;
   logic            upd_taken;
   logic [$clog2(DEP):0] inflight;
   logic            underflow;

   int checks = 0;
   int errors = 0;

   branch_resolve_ctrl #(
      .ADDRESS_WIDTH (AW),
      .GHR_SIZE      (GHR),
      .DEPTH         (DEP)
   ) dut (
      .i_Clk               (clk),
      .i_Reset             (rst),
      .i_Stall             (stall),
      .i_Pred_valid        (pred_valid),
      .i_Pred_pc           (pred_pc),
      .i_Pred_taken        (pred_taken),
      .i_Pred_ghr          (pred_ghr),
      .i_Resolve_valid     (res_valid),
      .i_Resolve_taken     (res_taken),
      .i_Resolve_target    (res_target),
      .o_Fetch_hold        (fetch_hold),
      .o_Flush             (flush),
      .o_Redirect_pc       (redirect_pc),
      .o_Ghr_restore_valid (ghr_rv),
      .o_Ghr_restore       (ghr_restore),
      .o_Update_valid      (upd_valid),
      .o_Update_index      (upd_index),
      .o_Update_taken      (upd_taken),
      .o_Inflight          (inflight),
      .o_Underflow         (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      pred_valid = 1'b0;
      res_valid  = 1'b0;
      stall      = 1'b0;
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pred(input logic [AW-1:0] pc, input logic [GHR-1:0] ghr, input logic tk);
      pred_valid = 1'b1;
      pred_pc    = pc;
      pred_ghr   = ghr;
      pred_taken = tk;
   endtask

   task automatic set_res(input logic tk, input logic [AW-1:0] tgt);
      res_valid  = 1'b1;
      res_taken  = tk;
      res_target = tgt;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      pred_pc = '0; pred_ghr = '0; pred_taken = 1'b0;
      res_taken = 1'b0; res_target = '0;
      #12;
      chk("rst_flush",     32'(flush), 0);
      chk("rst_upd_valid", 32'(upd_valid), 0);
      chk("rst_ghr_rv",    32'(ghr_rv), 0);
      chk("rst_inflight",  32'(inflight), 0);
      chk("rst_hold",      32'(fetch_hold), 0);
      chk("rst_underflow", 32'(underflow), 0);
      @(negedge clk);
      rst = 1'b0;
      step();

      // Three pushes
      set_pred(22'h10, 8'hFF, 1'b1); step();
      set_pred(22'h20, 8'h0F, 1'b1); step();
      set_pred(22'h30, 8'hFF, 1'b1); step();
      idle(); step();
      chk("t1_inflight", 32'(inflight), 3);
      chk("t1_hold",     32'(fetch_hold), 0);

      // Fill to DEPTH, then a dropped push
      set_pred(22'h40, 8'h00, 1'b1); step();
      chk("t2_full_inflight", 32'(inflight), 4);
      chk("t2_full_hold",     32'(fetch_hold), 1);
      set_pred(22'h44, 8'h00, 1'b1); step();
      chk("t2_drop_inflight", 32'(inflight), 4);
      chk("t2_drop_noupd",    32'(upd_valid), 0);

      // Push + correct resolve of head (0x10/0xFF) while full
      set_pred(22'h50, 8'h33, 1'b1);
      set_res(1'b1, 22'h99);
      step();
      idle();
      chk("t3_inflight",  32'(inflight), 4);
      chk("t3_upd_valid", 32'(upd_valid), 1);
      chk("t3_upd_index", 32'(upd_index), 32'hEF);
      chk("t3_upd_taken", 32'(upd_taken), 1);
      chk("t3_flush",     32'(flush), 0);
      step();
      chk("t3_upd_pulse", 32'(upd_valid), 0);

      // Mispredict on head 0x20/0x0F, with a simultaneous push that must be discarded
      set_pred(22'h60, 8'h12, 1'b1);
      set_res(1'b0, 22'h21);
      step();
      idle();
      chk("t4_flush",      32'(flush), 1);
      chk("t4_redirect",   32'(redirect_pc), 32'h21);
      chk("t4_ghr_rv",     32'(ghr_rv), 1);
      chk("t4_ghr",        32'(ghr_restore), 32'h1E);
      chk("t4_upd_valid",  32'(upd_valid), 1);
      chk("t4_upd_index",  32'(upd_index), 32'h2F);
      chk("t4_upd_taken",  32'(upd_taken), 0);
      chk("t4_inflight",   32'(inflight), 0);
      chk("t4_hold_flush", 32'(fetch_hold), 1);
      step();
      chk("t4_flush_pulse", 32'(flush), 0);
      chk("t4_rv_pulse",    32'(ghr_rv), 0);
      chk("t4_hold_recov",  32'(fetch_hold), 1);
      chk("t4_redir_hold",  32'(redirect_pc), 32'h21);
      step();
      chk("t4_hold_run",    32'(fetch_hold), 0);
      chk("t4_inflight2",   32'(inflight), 0);

      // Mispredict with stall during FLUSH; push during RECOVER ignored
      set_pred(22'h60, 8'hAA, 1'b0); step();
      idle();
      chk("t5_inflight", 32'(inflight), 1);
      set_res(1'b1, 22'h100); step();
      idle();
      chk("t5_flush",     32'(flush), 1);
      chk("t5_redirect",  32'(redirect_pc), 32'h100);
      chk("t5_ghr",       32'(ghr_restore), 32'h55);
      chk("t5_upd_index", 32'(upd_index), 32'hCA);
      chk("t5_upd_taken", 32'(upd_taken), 1);
      stall = 1'b1;
      step();
      chk("t5_stall_flush_done", 32'(flush), 0);
      chk("t5_stall_recov_hold", 32'(fetch_hold), 1);
      stall = 1'b0;
      set_pred(22'h70, 8'h01, 1'b1);
      step();
      idle();
      chk("t5_recov_push_ign", 32'(inflight), 0);
      chk("t5_run_hold",       32'(fetch_hold), 0);

      // Resolve while empty
      set_res(1'b1, 22'h0); step();
      idle();
      chk("t5_underflow",    32'(underflow), 1);
      chk("t5_uf_noupd",     32'(upd_valid), 0);
      step();
      chk("t5_uf_sticky",    32'(underflow), 1);

      // Reset asserted during FLUSH
      set_pred(22'h80, 8'h01, 1'b1); step();
      idle();
      set_res(1'b0, 22'h200); step();
      idle();
      chk("t6_flush", 32'(flush), 1);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_flush",     32'(flush), 0);
      chk("t6_rst_rv",        32'(ghr_rv), 0);
      chk("t6_rst_upd",       32'(upd_valid), 0);
      chk("t6_rst_redirect",  32'(redirect_pc), 0);
      chk("t6_rst_underflow", 32'(underflow), 0);
      chk("t6_rst_inflight",  32'(inflight), 0);
      chk("t6_rst_hold",      32'(fetch_hold), 0);
      @(negedge clk);
      rst = 1'b0;
      step();
      set_pred(22'h90, 8'h05, 1'b1); step();
      idle();
      chk("t6_post_inflight", 32'(inflight), 1);
      chk("t6_post_hold",     32'(fetch_hold), 0);
      set_res(1'b1, 22'h0); step();
      idle();
      chk("t6_post_upd_valid", 32'(upd_valid), 1);
      chk("t6_post_upd_index", 32'(upd_index), 32'h95);
      chk("t6_post_flush",     32'(flush), 0);
      chk("t6_post_inflight0", 32'(inflight), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
